// File: rtl/i2s_serializer.sv
// i2s_serializer: one-word holding buffer feeding a mono I2S transmitter.
// Each 64-slot frame sends the same word on the left and right channels, MSB first,
// with the standard one-bit I2S delay. audio_ready pulses at every frame start.
// Optional feature macro: I2S_SERIALIZER_UNDERRUN_CNT_EN enables the saturating
// underrun counter; without it underrun_count is tied to zero.
module i2s_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BCLK_DIV   = 4
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic                  x_valid,
  output logic                  x_ready,
  output logic                  bclk,
  output logic                  lrck,
  output logic                  dacdat,
  output logic                  audio_ready,
  output logic                  underrun,
  output logic [15:0]           underrun_count
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0]            div_cnt;
  logic [5:0]            slot;
  logic [5:0]            slot_nxt;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_word;
  logic [DATA_WIDTH-1:0] frame_word;
  logic                  div_tc;
  logic                  bclk_fall;
  logic                  frame_load;
  logic                  accept;
  logic                  dac_nxt;

  // x_ready is gated by rst so every output reads 0 while reset is held,
  // even if en is already high.
  assign x_ready     = rst & en & ~buf_full;
  assign accept      = x_valid & x_ready;
  assign div_tc      = (div_cnt == DIV_LAST);
  assign bclk_fall   = en & div_tc & bclk;
  assign frame_load  = bclk_fall & (slot == 6'd63);
  assign audio_ready = frame_load;
  assign underrun    = frame_load & ~buf_full;
  assign slot_nxt    = slot + 6'd1;

  // Bit for the slot being entered. Slot n carries bit DATA_WIDTH-1-((n-1) mod 32),
  // and (n-1) is the current slot, so slot[4:0] indexes directly; the 63->0 wrap
  // picks bit 0 of the outgoing frame word, which is the I2S-delayed right LSB.
  always_comb begin
    dac_nxt = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (32'(slot[4:0]) == i) dac_nxt = frame_word[DATA_WIDTH-1-i];
    end
  end

  // Bit clock divider, slot counter and serial outputs; all idle at 0 while disabled.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      slot    <= '0;
      lrck    <= 1'b0;
      dacdat  <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      slot    <= '0;
      lrck    <= 1'b0;
      dacdat  <= 1'b0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + 8'd1;
      if (div_tc) bclk <= ~bclk;
      if (bclk_fall) begin
        slot   <= slot_nxt;
        lrck   <= slot_nxt[5];
        dacdat <= dac_nxt;
      end
    end
  end

  // Holding buffer and frame word. A full buffer is consumed at frame load; an
  // empty one leaves the previous word in place for retransmission. An accept in
  // the same cycle as an empty-buffer load stays buffered for the next frame.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      buf_full   <= 1'b0;
      buf_word   <= '0;
      frame_word <= '0;
    end else if (!en) begin
      buf_full <= 1'b0;
    end else begin
      if (frame_load && buf_full) begin
        frame_word <= buf_word;
        buf_full   <= 1'b0;
      end else if (accept) begin
        buf_word <= x;
        buf_full <= 1'b1;
      end
    end
  end

`ifdef I2S_SERIALIZER_UNDERRUN_CNT_EN
  logic [15:0] ucnt;

  // Saturating underrun counter; survives en=0, cleared only by reset.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ucnt <= '0;
    end else if (underrun && (ucnt != '1)) begin
      ucnt <= ucnt + 16'd1;
    end
  end

  assign underrun_count = ucnt;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_i2s_serializer.sv
// tb_i2s_serializer: phase table plus cycle-accurate reference model and
// frame-word scoreboard for i2s_serializer (BCLK_DIV=2, 256 CLK per frame).
module tb_i2s_serializer;

`ifdef I2S_SERIALIZER_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        CLK;
  logic        rst;
  logic        en;
  logic [31:0] x;
  logic        x_valid;
  logic        x_ready;
  logic        bclk;
  logic        lrck;
  logic        dacdat;
  logic        audio_ready;
  logic        underrun;
  logic [15:0] underrun_count;

  i2s_serializer #(
    .DATA_WIDTH(32),
    .BCLK_DIV  (2)
  ) dut (
    .CLK           (CLK),
    .rst           (rst),
    .en            (en),
    .x             (x),
    .x_valid       (x_valid),
    .x_ready       (x_ready),
    .bclk          (bclk),
    .lrck          (lrck),
    .dacdat        (dacdat),
    .audio_ready   (audio_ready),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Reference model state: c counts rising edges since enable/reset.
  int unsigned c = 0;
  logic        m_full = 1'b0;
  logic [31:0] m_buf = '0;
  logic [31:0] m_frame = '0;
  logic        m_prev_lsb = 1'b0;
  logic        started = 1'b0;
  logic [15:0] m_ucnt = '0;
  logic [31:0] lw = '0;
  logic [31:0] sb[$];

  // Model checks every cycle at the falling CLK edge, then advances to the next rising edge.
  always @(negedge CLK) begin : monitor
    int unsigned slot;
    logic        exp_wrap;
    logic        exp_xr;
    logic        exp_b;
    logic        acc;
    logic [4:0]  bi;
    logic [31:0] w;
    if (!rst) begin
      chk("reset_outputs", {25'd0, x_ready, bclk, lrck, dacdat, audio_ready, underrun, 1'b0}, '0);
      chk("reset_ucnt", {16'd0, underrun_count}, '0);
      c = 0; m_full = 1'b0; m_buf = '0; m_frame = '0; m_prev_lsb = 1'b0;
      started = 1'b0; m_ucnt = '0; sb.delete();
    end else begin
      exp_wrap = en && ((c % 256) == 255);
      exp_xr   = en && !m_full;
      chk("x_ready", {31'd0, x_ready}, {31'd0, exp_xr});
      chk("audio_ready", {31'd0, audio_ready}, {31'd0, exp_wrap});
      chk("underrun", {31'd0, underrun}, {31'd0, exp_wrap && !m_full});
      chk("underrun_count", {16'd0, underrun_count}, {16'd0, CNT_EN ? m_ucnt : 16'd0});
      if (!en) begin
        chk("idle_serial", {29'd0, bclk, lrck, dacdat}, '0);
      end else begin
        chk("bclk", {31'd0, bclk}, {31'd0, (c % 4) >= 2});
        if ((c % 4) == 2) begin
          slot = (c / 4) % 64;
          chk("lrck", {31'd0, lrck}, {31'd0, slot >= 32});
          if (slot == 0) begin
            exp_b = started ? m_prev_lsb : 1'b0;
          end else if (slot <= 32) begin
            bi = 5'(32 - slot);
            exp_b = m_frame[bi];
          end else begin
            bi = 5'(64 - slot);
            exp_b = m_frame[bi];
          end
          chk("dacdat", {31'd0, dacdat}, {31'd0, exp_b});
          if (slot >= 1 && slot <= 32) lw = {lw[30:0], dacdat};
          if (slot == 32 && started) begin
            chk("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() != 0) begin
              w = sb.pop_front();
              chk("left_word", lw, w);
            end
          end
        end
      end
      acc = x_valid && exp_xr;
      if (!en) begin
        c = 0; m_full = 1'b0; started = 1'b0; sb.delete();
      end else begin
        if (exp_wrap) begin
          m_prev_lsb = m_frame[0];
          if (m_full) begin
            m_frame = m_buf;
            m_full  = 1'b0;
          end else if (m_ucnt != 16'hFFFF) begin
            m_ucnt = m_ucnt + 16'd1;
          end
          sb.push_back(m_frame);
          started = 1'b1;
        end
        if (acc) begin
          m_buf  = x;
          m_full = 1'b1;
        end
        c++;
      end
    end
  end

  // Phase table: mode 0 = no data, 1 = one word then drop x_valid, 2 = stream incrementing words.
  typedef struct {
    logic        en;
    int unsigned mode;
    logic [31:0] word;
    int unsigned cycles;
    int unsigned exp_aud;
    int unsigned exp_und;
    int unsigned exp_acc;
  } phase_t;

  localparam int unsigned NPH = 11;
  phase_t ph[NPH];

  initial begin : driver
    int unsigned na, nu, nacc, nf, lr_fall;
    logic acc, prev_b, seen;

    ph[0]  = '{1'b1, 1, 32'h8000_0001, 256, 1, 0, 1};
    ph[1]  = '{1'b1, 2, 32'h0000_0100, 768, 3, 0, 3};
    ph[2]  = '{1'b1, 0, 32'h0000_0000, 768, 3, 3, 0};
    ph[3]  = '{1'b1, 0, 32'h0000_0000, 255, 0, 0, 0};
    ph[4]  = '{1'b1, 1, 32'hA5A5_0F0F,   1, 1, 1, 1};
    ph[5]  = '{1'b1, 0, 32'h0000_0000, 256, 1, 0, 0};
    ph[6]  = '{1'b1, 0, 32'h0000_0000, 256, 1, 1, 0};
    ph[7]  = '{1'b1, 1, 32'h1234_5678, 100, 0, 0, 1};
    ph[8]  = '{1'b0, 1, 32'hDEAD_BEEF,  10, 0, 0, 0};
    ph[9]  = '{1'b1, 0, 32'h0000_0000, 256, 1, 1, 0};
    ph[10] = '{1'b1, 2, 32'h0000_0200,  82, 0, 0, 1};

    rst = 1'b0; en = 1'b0; x_valid = 1'b0; x = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("por_outputs", {25'd0, x_ready, bclk, lrck, dacdat, audio_ready, underrun, 1'b0}, '0);
    rst = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    for (int i = 0; i < NPH; i++) begin
      en      = ph[i].en;
      x_valid = (ph[i].mode != 0);
      if (ph[i].mode != 0) x = ph[i].word;
      na = 0; nu = 0; nacc = 0;
      for (int unsigned k = 0; k < ph[i].cycles; k++) begin
        @(negedge CLK);
        if (audio_ready) na++;
        if (underrun) nu++;
        acc = x_valid && x_ready;
        if (acc) nacc++;
        @(posedge CLK);
        #1;
        if (acc && ph[i].mode == 2) x = x + 32'd1;
        if (acc && ph[i].mode == 1) x_valid = 1'b0;
      end
      chk($sformatf("ph%0d_audio_ready", i), na, ph[i].exp_aud);
      chk($sformatf("ph%0d_underrun", i), nu, ph[i].exp_und);
      chk($sformatf("ph%0d_accepts", i), nacc, ph[i].exp_acc);
      if (i == 2) chk("ucnt_after_gap", {16'd0, underrun_count}, CNT_EN ? 32'd3 : 32'd0);
    end

    // Now in slot 20 of a frame: assert reset asynchronously mid-cycle.
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_outputs", {25'd0, x_ready, bclk, lrck, dacdat, audio_ready, underrun, 1'b0}, '0);
    chk("async_rst_ucnt", {16'd0, underrun_count}, '0);
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b1; en = 1'b1; x_valid = 1'b0;
    nf = 0; lr_fall = 0; prev_b = 1'b0; seen = 1'b0;
    repeat (400) begin
      @(negedge CLK);
      if (prev_b && !bclk) nf++;
      prev_b = bclk;
      if (lrck && !seen) begin
        seen    = 1'b1;
        lr_fall = nf;
      end
    end
    chk("lrck_rise_seen", {31'd0, seen}, 32'd1);
    chk("lrck_rise_fall_index", lr_fall, 32'd32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/i2s_serializer.md
I2S_SERIALIZER -- requirements
Module: i2s_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: sample word width and slots per channel.
REQ-002 SHALL have parameter BCLK_DIV, default 4: CLK cycles per BCLK half-period; legal range 1..255.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  serializer enable.
REQ-006 SHALL have port x  input  DATA_WIDTH  sample word from the effect chain, two's complement.
REQ-007 SHALL have port x_valid  input  1  x holds a valid word this cycle.
REQ-008 SHALL have port x_ready  output  1  holding buffer can accept a word.
REQ-009 SHALL have port bclk  output  1  codec bit clock.
REQ-010 SHALL have port lrck  output  1  codec word select; 0 = left, 1 = right.
REQ-011 SHALL have port dacdat  output  1  serial data to codec DAC.
REQ-012 SHALL have port audio_ready  output  1  one-CLK pulse at each frame start; requests the next sample.
REQ-013 SHALL have port underrun  output  1  one-CLK pulse when a frame starts with an empty buffer.
REQ-014 SHALL have port underrun_count  output  16  saturating underrun count.

Function
REQ-015 SHALL accept x into a one-word holding buffer on any CLK edge where x_valid and x_ready are both 1.
REQ-016 SHALL drive x_ready = en AND buffer empty; it SHALL fall in the cycle after an accept.
REQ-017 SHALL count CLK cycles 0..BCLK_DIV-1 and toggle bclk at terminal count; bclk period = 2*BCLK_DIV CLK.
REQ-018 SHALL keep a 6-bit slot counter that advances on each bclk falling edge and wraps 63->0.
REQ-019 SHALL change lrck and dacdat only on bclk falling edges.
REQ-020 SHALL drive lrck = 0 for slots 0..31 and 1 for slots 32..63.
REQ-021 SHALL use I2S delay: in slot s, dacdat = frame word bit DATA_WIDTH-1-((s-1) mod 32); slot 0 carries the previous right-channel LSB.
REQ-022 SHALL transmit the same frame word on left and right (mono), MSB first.
REQ-023 SHALL load the frame word when the slot counter wraps 63->0 and pulse audio_ready in that cycle.
REQ-024 At frame load with buffer full: SHALL move the buffer to the frame word and mark the buffer empty.
REQ-025 At frame load with buffer empty: SHALL retransmit the previous frame word and pulse underrun.
REQ-026 Accept and frame load in the same cycle with buffer empty: SHALL count an underrun; the accepted word stays buffered for the next frame.
REQ-027 SHALL, with en=0: hold bclk, lrck, dacdat, audio_ready and underrun at 0, clear the counters, and empty the buffer; underrun_count SHALL be retained.
REQ-028 After en rises, SHALL start at slot 0 with BCLK counter 0; the first frame load occurs at the first 63->0 wrap.

Reset
REQ-029 While rst=0, all outputs SHALL be 0, and the buffer, frame word and all counters SHALL be cleared.
REQ-030 SHALL abort any transfer in progress on asynchronous reset assertion; no partial word SHALL resume after release.

Configuration
REQ-031 With macro I2S_SERIALIZER_UNDERRUN_CNT_EN defined, underrun_count SHALL increment on each underrun pulse and saturate at 16'hFFFF.
REQ-032 Without I2S_SERIALIZER_UNDERRUN_CNT_EN, underrun_count SHALL be constant 0; the underrun pulse is unaffected.

Verification (BCLK_DIV=2, frame = 256 CLK)
REQ-033 Reset released, en=1, x=32'h80000001 valid -> x_ready falls the next cycle; after the first wrap, dacdat in slots 1..32 = 1,0..0,1; lrck rises at slot 32.
REQ-034 Continuous x_valid with an incrementing word -> one accept per frame; audio_ready period is exactly 256 CLK; no underrun.
REQ-035 No x_valid for 3 frames -> underrun pulses 3 times, the last word repeats, underrun_count = 3 with the macro and 0 without it.
REQ-036 Accept coinciding with a wrap while empty -> underrun=1 that cycle; the word appears in the next frame.
REQ-037 rst asserted at slot 20 -> all outputs 0 immediately; after release, the first lrck edge comes 32 bclk periods after the first falling edge.
REQ-038 en dropped mid-frame for 10 CLK, then raised -> outputs 0 and buffer empty; x_ready=1 after en rises; underrun_count is unchanged.
